// File: rtl/matrix_result_drain.sv
// Captures a 4x4 result matrix in one cycle and streams its 16 elements over valid/ready.
// Define MATRIX_DRAIN_COL_MAJOR_EN to emit elements in column-major order instead of row-major.
module matrix_result_drain #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  capture,
  input  logic [0:3][0:3][DATA_WIDTH-1:0]       result,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [1:0]                            out_row,
  output logic [1:0]                            out_col,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  capture_drop
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [3:0]                   idx_q, idx_d;
  logic [15:0][DATA_WIDTH-1:0]  mat_q, mat_d;
  logic                         done_q, done_d;
  logic                         drop_q, drop_d;
  logic [1:0]                   row, col;
  logic                         streaming;
  logic                         transfer;
  logic                         final_beat;

  // The buffer is always stored row-major; only the walk order changes.
  always_comb begin
`ifdef MATRIX_DRAIN_COL_MAJOR_EN
    row = idx_q[1:0];
    col = idx_q[3:2];
`else
    row = idx_q[3:2];
    col = idx_q[1:0];
`endif
  end

  assign streaming  = (state_q == STREAM);
  assign transfer   = streaming && out_ready;
  assign final_beat = (idx_q == 4'hF);

  assign out_valid    = streaming;
  assign busy         = streaming;
  assign out_row      = streaming ? row : 2'd0;
  assign out_col      = streaming ? col : 2'd0;
  assign out_data     = streaming ? mat_q[{row, col}] : '0;
  assign out_last     = streaming && final_beat;
  assign done         = done_q;
  assign capture_drop = drop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mat_d   = mat_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;

    if (clear) begin
      state_d = IDLE;
      idx_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            for (int r = 0; r < 4; r++) begin
              for (int c = 0; c < 4; c++) begin
                mat_d[r*4 + c] = result[r][c];
              end
            end
            idx_d   = 4'd0;
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (transfer && final_beat) begin
            done_d = 1'b1;
            idx_d  = 4'd0;
            // A capture coinciding with the final handshake chains a new drain with no bubble.
            if (capture) begin
              for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                  mat_d[r*4 + c] = result[r][c];
                end
              end
              state_d = STREAM;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (transfer) begin
              idx_d = idx_q + 4'd1;
            end
            if (capture) begin
              drop_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      mat_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mat_q   <= mat_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

endmodule
